// File: rtl/unsigned_product_accumulator.sv
// rtl/unsigned_product_accumulator.sv - sums NUM_TERMS multiplier products into one result
//
// Consumes unsigned products from the 4-bit array multiplier and adds a
// fixed number of them into a single result, with valid/ready handshakes
// on both sides.
//
// Optional feature macro: UNSIGNED_PRODUCT_ACCUMULATOR_SATURATION_EN
//   defined   -> an overflowing add clamps the accumulator to all ones for
//                the rest of that accumulation
//   undefined -> the accumulator wraps modulo 2^ACC_WIDTH
//
// Ports:
//   Clock_In          rising-edge clock
//   Reset_In          synchronous active-high reset
//   Enable_In         1 = accept products, 0 = input side stalled
//   Product_In        product from the multiplier
//   Product_Valid_In  Product_In valid this cycle
//   Product_Ready_Out block can accept a product this cycle
//   Result_Out        accumulated sum, stable while Result_Valid_Out=1
//   Result_Valid_Out  Result_Out holds a completed sum
//   Result_Ready_In   downstream accepts the result
//   Overflow_Out      sticky: a carry left ACC_WIDTH during this accumulation
//   Term_Count_Out    products accepted so far in the current accumulation

module unsigned_product_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TERMS  = 4,
    parameter int ACC_WIDTH  = 10
) (
    input  logic                         Clock_In,
    input  logic                         Reset_In,
    input  logic                         Enable_In,
    input  logic [DATA_WIDTH-1:0]        Product_In,
    input  logic                         Product_Valid_In,
    output logic                         Product_Ready_Out,
    output logic [ACC_WIDTH-1:0]         Result_Out,
    output logic                         Result_Valid_Out,
    input  logic                         Result_Ready_In,
    output logic                         Overflow_Out,
    output logic [$clog2(NUM_TERMS)-1:0] Term_Count_Out
);

    localparam int CNT_W = $clog2(NUM_TERMS);
    localparam int SUM_W = ACC_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_TERMS - 1);

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     count;
    logic                 ovf;

    logic                 accept;
    logic [SUM_W-1:0]     product_ext;
    logic [SUM_W-1:0]     sum;
    logic [ACC_WIDTH-1:0] next_acc;

    assign Product_Ready_Out = Enable_In & (state != DONE);
    // Enable_In gates the AND first, so an X on Product_Valid_In while
    // disabled cannot turn into an accept.
    assign accept            = Product_Ready_Out & Product_Valid_In;

    assign product_ext = SUM_W'(Product_In);
    // acc is held at zero in IDLE, so the same adder serves the first term.
    assign sum         = {1'b0, acc} + product_ext;

`ifdef UNSIGNED_PRODUCT_ACCUMULATOR_SATURATION_EN
    // Once clamped, stay clamped until the result is consumed or reset.
    assign next_acc = (sum[ACC_WIDTH] | ovf) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign next_acc = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACCUM;
                        acc   <= next_acc;
                        ovf   <= sum[ACC_WIDTH];
                        count <= CNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= next_acc;
                        ovf <= ovf | sum[ACC_WIDTH];
                        if (count == LAST_COUNT) begin
                            state <= DONE;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (Result_Ready_In) begin
                        state <= IDLE;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    count <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

    // The finished sum lives in acc while in DONE.
    assign Result_Out       = acc;
    assign Result_Valid_Out = (state == DONE);
    assign Overflow_Out     = ovf;
    assign Term_Count_Out   = count;

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
// tb/tb_unsigned_product_accumulator.sv - directed self-checking bench for unsigned_product_accumulator

module tb_unsigned_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] prod;
    logic       pvalid;
    logic       rready;

    logic       ready_w,  valid_w,  ovf_w;
    logic [9:0] result_w;
    logic [1:0] count_w;

    logic       ready_n,  valid_n,  ovf_n;
    logic [7:0] result_n;
    logic [1:0] count_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unsigned_product_accumulator #(.DATA_WIDTH(8), .NUM_TERMS(4), .ACC_WIDTH(10)) dut_w (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en),
        .Product_In(prod), .Product_Valid_In(pvalid), .Product_Ready_Out(ready_w),
        .Result_Out(result_w), .Result_Valid_Out(valid_w), .Result_Ready_In(rready),
        .Overflow_Out(ovf_w), .Term_Count_Out(count_w)
    );

    unsigned_product_accumulator #(.DATA_WIDTH(8), .NUM_TERMS(4), .ACC_WIDTH(8)) dut_n (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en),
        .Product_In(prod), .Product_Valid_In(pvalid), .Product_Ready_Out(ready_n),
        .Result_Out(result_n), .Result_Valid_Out(valid_n), .Result_Ready_In(rready),
        .Overflow_Out(ovf_n), .Term_Count_Out(count_n)
    );

`ifdef UNSIGNED_PRODUCT_ACCUMULATOR_SATURATION_EN
    localparam logic [31:0] NARROW_E1X4 = 32'h0FF;
`else
    localparam logic [31:0] NARROW_E1X4 = 32'h084;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [7:0] p);
        prod   = p;
        pvalid = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; prod = 8'h00; pvalid = 1'b0; rready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_valid",  32'(valid_w),  32'd0);
        chk("reset_result", 32'(result_w), 32'd0);
        chk("reset_ovf",    32'(ovf_w),    32'd0);
        chk("reset_count",  32'(count_w),  32'd0);
        chk("reset_ready",  32'(ready_w),  32'd1);

        // Back-to-back products, result consumed immediately.
        rready = 1'b1;
        feed(8'h06);
        chk("t1_count1", 32'(count_w), 32'd1);
        feed(8'h0F);
        feed(8'h51);
        feed(8'h00);
        pvalid = 1'b0;
        #1;
        chk("t1_valid",  32'(valid_w),  32'd1);
        chk("t1_result", 32'(result_w), 32'h066);
        chk("t1_ovf",    32'(ovf_w),    32'd0);
        chk("t1_ready",  32'(ready_w),  32'd0);
        tick();
        chk("t1_valid_one_cycle", 32'(valid_w), 32'd0);

        // Max products; narrow instance overflows. Then back-pressure.
        rready = 1'b0;
        feed(8'hE1);
        feed(8'hE1);
        feed(8'hE1);
        feed(8'hE1);
        chk("t2_result",   32'(result_w), 32'h384);
        chk("t2_ovf",      32'(ovf_w),    32'd0);
        chk("t2n_result",  32'(result_n), NARROW_E1X4);
        chk("t2n_ovf",     32'(ovf_n),    32'd1);
        prod = 8'h01;
        pvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_hold_ready",  32'(ready_w),  32'd0);
            chk("t2_hold_valid",  32'(valid_w),  32'd1);
            chk("t2_hold_result", 32'(result_w), 32'h384);
            chk("t2_hold_count",  32'(count_w),  32'd0);
            tick();
        end
        pvalid = 1'b0;
        rready = 1'b1;
        tick();
        chk("t2_release_valid",  32'(valid_w),  32'd0);
        chk("t2_release_result", 32'(result_w), 32'd0);
        chk("t2n_release_ovf",   32'(ovf_n),    32'd0);

        // Fresh accumulation after overflow clears the flag.
        feed(8'h01);
        feed(8'h01);
        feed(8'h01);
        feed(8'h01);
        pvalid = 1'b0;
        chk("t3n_result", 32'(result_n), 32'h004);
        chk("t3n_ovf",    32'(ovf_n),    32'd0);
        chk("t3_result",  32'(result_w), 32'h004);
        tick();

        // Enable stall mid-accumulation.
        feed(8'h10);
        feed(8'h20);
        en = 1'b0;
        prod = 8'h30;
        pvalid = 1'b1;
        #1;
        chk("t4_stall_ready", 32'(ready_w), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_count", 32'(count_w), 32'd2);
        end
        en = 1'b1;
        feed(8'h30);
        feed(8'h40);
        pvalid = 1'b0;
        chk("t4_valid",  32'(valid_w),  32'd1);
        chk("t4_result", 32'(result_w), 32'h0A0);
        tick();

        // Reset mid-accumulation discards the partial sum.
        feed(8'h10);
        feed(8'h20);
        pvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_count", 32'(count_w), 32'd0);
        chk("t5_valid", 32'(valid_w), 32'd0);
        feed(8'h01);
        feed(8'h01);
        feed(8'h01);
        feed(8'h01);
        pvalid = 1'b0;
        chk("t5_result", 32'(result_w), 32'h004);
        tick();

        // Reset while a result is pending.
        rready = 1'b0;
        feed(8'hE1);
        feed(8'hE1);
        feed(8'hE1);
        feed(8'hE1);
        pvalid = 1'b0;
        chk("t6_pre_valid", 32'(valid_n), 32'd1);
        chk("t6_pre_ovf",   32'(ovf_n),   32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid",   32'(valid_w),  32'd0);
        chk("t6_result",  32'(result_w), 32'd0);
        chk("t6n_result", 32'(result_n), 32'd0);
        chk("t6n_ovf",    32'(ovf_n),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_product_accumulator.md
Name: unsigned_product_accumulator

Overview:
- Downstream stage of the 4-bit unsigned array multiplier: consumes its 8-bit products and sums a fixed number of them (NUM_TERMS) into one unsigned result.
- Valid/ready handshake on the input and output sides. Enable gating matches the multiplier.
- Used to build dot-product / MAC datapaths from the combinational multiplier.

Parameters:
- DATA_WIDTH, 8, width of each incoming product (multiplier output width).
- NUM_TERMS, 4, products summed per result; legal range 2..256.
- ACC_WIDTH, 10, accumulator/result width; DATA_WIDTH+clog2(NUM_TERMS) guarantees no overflow; smaller values are legal.

Ports:
- Clock_In  input  1  single clock; all state updates on rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Enable_In  input  1  1 = accept products; 0 = input side stalled, state held.
- Product_In  input  DATA_WIDTH  product from multiplier (Multiplied_Result_Out).
- Product_Valid_In  input  1  Product_In valid this cycle.
- Product_Ready_Out  output  1  block can accept a product this cycle.
- Result_Out  output  ACC_WIDTH  accumulated sum; stable while Result_Valid_Out=1.
- Result_Valid_Out  output  1  Result_Out holds a completed sum.
- Result_Ready_In  input  1  downstream accepts result.
- Overflow_Out  output  1  sticky per result: a carry left ACC_WIDTH during this accumulation.
- Term_Count_Out  output  clog2(NUM_TERMS)  products accepted so far in the current accumulation.

Behaviour:
- Reset (Reset_In=1 at an edge): state=IDLE, acc=0, count=0, Overflow_Out=0, Result_Valid_Out=0, Result_Out=0. Reset wins over every other event, including mid-accumulation or a pending result. Any partial sum is discarded.
- Product_Ready_Out = Enable_In & (state != DONE). It is combinational from state and Enable_In only.
- Accept = Product_Valid_In & Product_Ready_Out.
- FSM states IDLE, ACCUM, DONE:
  - IDLE: acc=0, count=0.
    - Accept with NUM_TERMS>1 -> ACCUM, acc=Product_In, count=1.
  - ACCUM:
    - Accept with count<NUM_TERMS-1 -> acc+=Product_In, count++.
    - Accept with count==NUM_TERMS-1 -> DONE, Result_Out=acc+Product_In, count=0.
    - No accept -> hold everything.
  - DONE: Result_Valid_Out=1, Product_Ready_Out=0.
    - Result_Ready_In=1 -> IDLE next edge: Result_Valid_Out=0, acc=0, Overflow_Out=0.
    - Otherwise hold Result_Out, Overflow_Out and Result_Valid_Out unchanged.
- Latency: Result_Valid_Out asserts on the edge that accepts the last product, so it is visible the cycle after that accept.
- Throughput: at best NUM_TERMS+1 cycles per result, with one bubble cycle in DONE. A product offered while in DONE is not accepted and must be held by the source.
- Arithmetic:
  - Products are zero-extended to ACC_WIDTH.
  - Sum is computed at ACC_WIDTH+1 bits. Bit ACC_WIDTH set -> Overflow_Out set (sticky until result consumed or reset).
  - Stored value is the low ACC_WIDTH bits, i.e. wraps modulo 2^ACC_WIDTH.
- Enable_In=0: no accept; FSM, acc and count hold. The output handshake in DONE still completes normally.
- Product_Valid_In with X/Z and Enable_In=0: ignored.
- Result_Ready_In outside DONE: ignored.
- Product_In=0: counts as a term normally.

Optional Feature:
- Macro: UNSIGNED_PRODUCT_ACCUMULATOR_SATURATION_EN.
- Defined: on an overflowing add, acc clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of that accumulation. Overflow_Out still asserts.
- Undefined: wrap-around modulo 2^ACC_WIDTH as described above.
- Default (no overflow) configuration: behaviour is identical either way.

Test Plan:
- Defaults; after reset, feed products 0x06, 0x0F, 0x51, 0x00 back-to-back with valid=1, Result_Ready_In=1 -> Result_Out=0x066 with Result_Valid_Out high for exactly 1 cycle, Overflow_Out=0, Product_Ready_Out low during that DONE cycle.
- Defaults; four products 0xE1 (15*15) -> Result_Out=0x384 (900), Overflow_Out=0. Then hold Result_Ready_In=0 for 5 cycles with valid product 0x01 offered -> result stable, Product_Ready_Out=0, no product accepted.
- ACC_WIDTH=8; four products 0xE1:
  - Macro undefined -> Result_Out=0x84, Overflow_Out=1.
  - Macro defined -> Result_Out=0xFF, Overflow_Out=1.
  - Next accumulation of 0x01 x4 -> Result_Out=0x04, Overflow_Out=0.
- Defaults; accept 0x10, 0x20, then Enable_In=0 for 3 cycles with valid high -> Term_Count_Out stays 2, Product_Ready_Out=0. Re-enable, send 0x30, 0x40 -> Result_Out=0x0A0.
- Defaults; accept 0x10, 0x20, assert Reset_In for 1 cycle -> next cycle Term_Count_Out=0, Result_Valid_Out=0. Then 4x 0x01 -> Result_Out=0x004.
- Defaults; assert Reset_In while in DONE with Result_Ready_In=0 -> Result_Valid_Out=0, Result_Out=0, Overflow_Out=0 the next cycle.
